// File: rtl/note_timer_multi_if.sv
// Bus between the note player (master) and the multi-channel note timer (slave).
// Optional NOTE_TIMER_AUTORELOAD_EN adds the per-channel auto_repeat request.
interface note_timer_multi_if #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 6,
  parameter int SEL_W  = 2
);
  logic                    beat;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*LEN_W-1:0] note_length;
  logic [NUM_CH-1:0]       pause;
  logic [SEL_W-1:0]        rd_sel;
`ifdef NOTE_TIMER_AUTORELOAD_EN
  logic [NUM_CH-1:0]       auto_repeat;
`endif
  logic [NUM_CH-1:0]       note_did_end;
  logic [NUM_CH-1:0]       note_end_pulse;
  logic [2*NUM_CH-1:0]     ch_state;
  logic                    any_running;
  logic [LEN_W-1:0]        rd_count;

  modport master (
`ifdef NOTE_TIMER_AUTORELOAD_EN
    output auto_repeat,
`endif
    output beat, load, note_length, pause, rd_sel,
    input  note_did_end, note_end_pulse, ch_state, any_running, rd_count
  );

  modport slave (
`ifdef NOTE_TIMER_AUTORELOAD_EN
    input  auto_repeat,
`endif
    input  beat, load, note_length, pause, rd_sel,
    output note_did_end, note_end_pulse, ch_state, any_running, rd_count
  );
endinterface

// File: rtl/note_timer_multi.sv
// NUM_CH independent note-length countdown timers sharing one beat strobe.
// Define NOTE_TIMER_AUTORELOAD_EN to add per-channel auto-repeat with reload registers.
module note_timer_multi #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 6,
  parameter int SEL_W  = 2
) (
  input logic                clk,
  input logic                reset_n,
  note_timer_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  logic [LEN_W-1:0]  count_q [NUM_CH];
  ch_state_e         state_q [NUM_CH];
  logic [NUM_CH-1:0] pulse_q;
  logic [LEN_W-1:0]  reload_val [NUM_CH];
  logic [NUM_CH-1:0] rearm;

`ifdef NOTE_TIMER_AUTORELOAD_EN
  logic [LEN_W-1:0] reload_q [NUM_CH];

  // A zero reload value degrades the channel to one-shot.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      reload_val[i] = reload_q[i];
      rearm[i]      = bus.auto_repeat[i] && (reload_q[i] != '0);
    end
  end
`else
  always_comb begin
    rearm = '0;
    for (int i = 0; i < NUM_CH; i++) reload_val[i] = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pulse_q <= '0;
      // NOTE: these per-channel arrays are small flop banks, not RAM, so clearing them all in reset is intended.
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
        state_q[i] <= ST_IDLE;
`ifdef NOTE_TIMER_AUTORELOAD_EN
        reload_q[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pulse_q[i] <= 1'b0;
        if (bus.load[i]) begin
          count_q[i] <= bus.note_length[i*LEN_W +: LEN_W];
          state_q[i] <= (bus.note_length[i*LEN_W +: LEN_W] != '0) ? ST_RUN : ST_DONE;
`ifdef NOTE_TIMER_AUTORELOAD_EN
          reload_q[i] <= bus.note_length[i*LEN_W +: LEN_W];
`endif
        end else if (bus.pause[i]) begin
          count_q[i] <= count_q[i];
          state_q[i] <= state_q[i];
        end else if (bus.beat) begin
          if (state_q[i] == ST_RUN) begin
            if (count_q[i] > LEN_W'(1)) begin
              count_q[i] <= count_q[i] - LEN_W'(1);
            end else begin
              pulse_q[i] <= 1'b1;
              if (rearm[i]) begin
                count_q[i] <= reload_val[i];
              end else begin
                count_q[i] <= '0;
                state_q[i] <= ST_DONE;
              end
            end
          end else begin
            // Beats outside RUN saturate at zero rather than wrapping.
            count_q[i] <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    bus.ch_state     = '0;
    bus.note_did_end = '0;
    bus.any_running  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_state[2*i +: 2] = state_q[i];
      bus.note_did_end[i]    = (count_q[i] == '0) && !bus.load[i];
      bus.any_running        = bus.any_running || (state_q[i] == ST_RUN);
    end
  end

  assign bus.note_end_pulse = pulse_q;

  // Unused select codes (rd_sel >= NUM_CH) read back as zero.
  always_comb begin
    bus.rd_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_sel == SEL_W'(i)) bus.rd_count = count_q[i];
    end
  end

endmodule

// File: tb/tb_note_timer_multi.sv
// Directed self-checking bench for note_timer_multi (4 channels, 6-bit lengths).
module tb_note_timer_multi;
  localparam int NUM_CH = 4;
  localparam int LEN_W  = 6;
  localparam int SEL_W  = 2;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  note_timer_multi_if #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .SEL_W(SEL_W)) tif ();

  note_timer_multi #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .SEL_W(SEL_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic give_beat();
    tif.beat = 1'b1;
    tick();
    tif.beat = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (tif.note_did_end !== 4'hF) begin errors++; $display("FAIL reset_did_end got %b exp 1111", tif.note_did_end); end
    checks++; if (tif.ch_state !== 8'h00) begin errors++; $display("FAIL reset_state got %h exp 00", tif.ch_state); end
    checks++; if (tif.any_running !== 1'b0) begin errors++; $display("FAIL reset_any_running got %b exp 0", tif.any_running); end
    checks++; if (tif.note_end_pulse !== 4'h0) begin errors++; $display("FAIL reset_pulse got %b exp 0000", tif.note_end_pulse); end
    for (int s = 0; s < 4; s++) begin
      tif.rd_sel = SEL_W'(s);
      #1;
      checks++; if (tif.rd_count !== 6'd0) begin errors++; $display("FAIL reset_count%0d got %0d exp 0", s, tif.rd_count); end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_countdown();
    tif.rd_sel = 2'd0;
    tif.note_length[0 +: LEN_W] = 6'd3;
    tif.load = 4'b0001;
    #1;
    checks++; if (tif.note_did_end[0] !== 1'b0) begin errors++; $display("FAIL cd_load_mask got %b exp 0", tif.note_did_end[0]); end
    tick();
    tif.load = 4'b0000;
    #1;
    checks++; if (tif.rd_count !== 6'd3) begin errors++; $display("FAIL cd_loaded got %0d exp 3", tif.rd_count); end
    checks++; if (tif.ch_state[1:0] !== 2'd1) begin errors++; $display("FAIL cd_state_run got %0d exp 1", tif.ch_state[1:0]); end
    checks++; if (tif.any_running !== 1'b1) begin errors++; $display("FAIL cd_any_running got %b exp 1", tif.any_running); end
    for (int k = 0; k < 3; k++) begin
      repeat (3) begin
        tick();
        checks++; if (tif.note_end_pulse[0] !== 1'b0) begin errors++; $display("FAIL cd_idle_pulse got %b exp 0", tif.note_end_pulse[0]); end
      end
      give_beat();
      checks++; if (tif.rd_count !== 6'(2 - k)) begin errors++; $display("FAIL cd_count got %0d exp %0d", tif.rd_count, 2 - k); end
      checks++; if (tif.note_end_pulse[0] !== (k == 2)) begin errors++; $display("FAIL cd_pulse got %b exp %b", tif.note_end_pulse[0], k == 2); end
      checks++; if (tif.note_did_end[0] !== (k == 2)) begin errors++; $display("FAIL cd_did_end got %b exp %b", tif.note_did_end[0], k == 2); end
      checks++; if (tif.ch_state[1:0] !== ((k == 2) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL cd_state got %0d", tif.ch_state[1:0]); end
    end
    tick();
    checks++; if (tif.note_end_pulse[0] !== 1'b0) begin errors++; $display("FAIL cd_pulse_width got %b exp 0", tif.note_end_pulse[0]); end
    checks++; if (tif.any_running !== 1'b0) begin errors++; $display("FAIL cd_any_running_done got %b exp 0", tif.any_running); end
    give_beat();
    checks++; if (tif.rd_count !== 6'd0) begin errors++; $display("FAIL cd_saturate got %0d exp 0", tif.rd_count); end
    checks++; if (tif.note_end_pulse[0] !== 1'b0) begin errors++; $display("FAIL cd_done_beat_pulse got %b exp 0", tif.note_end_pulse[0]); end
    checks++; if (tif.ch_state[1:0] !== 2'd2) begin errors++; $display("FAIL cd_done_hold got %0d exp 2", tif.ch_state[1:0]); end
  endtask

  task automatic test_pause();
    tif.rd_sel = 2'd1;
    tif.note_length[LEN_W +: LEN_W] = 6'd5;
    tif.load = 4'b0010;
    tick();
    tif.load = 4'b0000;
    tif.pause = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      give_beat();
      checks++; if (tif.rd_count !== 6'd5) begin errors++; $display("FAIL pause_hold got %0d exp 5", tif.rd_count); end
      checks++; if (tif.ch_state[3:2] !== 2'd1) begin errors++; $display("FAIL pause_state got %0d exp 1", tif.ch_state[3:2]); end
      tick();
    end
    tif.pause = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      give_beat();
      checks++; if (tif.rd_count !== 6'(5 - k)) begin errors++; $display("FAIL pause_run got %0d exp %0d", tif.rd_count, 5 - k); end
      checks++; if (tif.note_end_pulse[1] !== (k == 5)) begin errors++; $display("FAIL pause_pulse got %b exp %b", tif.note_end_pulse[1], k == 5); end
      tick();
    end
    checks++; if (tif.ch_state[3:2] !== 2'd2) begin errors++; $display("FAIL pause_done got %0d exp 2", tif.ch_state[3:2]); end
  endtask

  task automatic test_load_priority();
    tif.rd_sel = 2'd2;
    tif.note_length[2*LEN_W +: LEN_W] = 6'd4;
    tif.load = 4'b0100;
    tif.beat = 1'b1;
    #1;
    checks++; if (tif.note_did_end[2] !== 1'b0) begin errors++; $display("FAIL lp_mask got %b exp 0", tif.note_did_end[2]); end
    tick();
    tif.load = 4'b0000;
    tif.beat = 1'b0;
    #1;
    checks++; if (tif.rd_count !== 6'd4) begin errors++; $display("FAIL lp_beat_ignored got %0d exp 4", tif.rd_count); end
    checks++; if (tif.ch_state[5:4] !== 2'd1) begin errors++; $display("FAIL lp_state got %0d exp 1", tif.ch_state[5:4]); end
    tif.note_length[3*LEN_W +: LEN_W] = 6'd0;
    tif.load = 4'b1000;
    #1;
    checks++; if (tif.note_did_end[3] !== 1'b0) begin errors++; $display("FAIL lz_mask got %b exp 0", tif.note_did_end[3]); end
    tick();
    tif.load = 4'b0000;
    tif.rd_sel = 2'd3;
    #1;
    checks++; if (tif.ch_state[7:6] !== 2'd2) begin errors++; $display("FAIL lz_state got %0d exp 2", tif.ch_state[7:6]); end
    checks++; if (tif.note_end_pulse[3] !== 1'b0) begin errors++; $display("FAIL lz_pulse got %b exp 0", tif.note_end_pulse[3]); end
    checks++; if (tif.note_did_end[3] !== 1'b1) begin errors++; $display("FAIL lz_did_end got %b exp 1", tif.note_did_end[3]); end
    checks++; if (tif.rd_count !== 6'd0) begin errors++; $display("FAIL lz_count got %0d exp 0", tif.rd_count); end
  endtask

  task automatic test_back_to_back();
    // ch2 is still running from 4 here
    tif.rd_sel = 2'd0;
    tif.note_length[0 +: LEN_W] = 6'd2;
    tif.note_length[LEN_W +: LEN_W] = 6'd2;
    tif.load = 4'b0011;
    tick();
    tif.load = 4'b0000;
    give_beat();
    checks++; if (tif.note_end_pulse !== 4'b0000) begin errors++; $display("FAIL bb_early_pulse got %b exp 0000", tif.note_end_pulse); end
    give_beat();
    checks++; if (tif.note_end_pulse !== 4'b0011) begin errors++; $display("FAIL bb_pulse got %b exp 0011", tif.note_end_pulse); end
    checks++; if (tif.note_did_end !== 4'b1011) begin errors++; $display("FAIL bb_did_end got %b exp 1011", tif.note_did_end); end
    tick();
    checks++; if (tif.note_end_pulse !== 4'b0000) begin errors++; $display("FAIL bb_pulse_clear got %b exp 0000", tif.note_end_pulse); end
    tif.note_length[0 +: LEN_W] = 6'd5;
    tif.load = 4'b0001;
    tick();
    tif.load = 4'b0000;
    give_beat();
    checks++; if (tif.rd_count !== 6'd4) begin errors++; $display("FAIL rl_count got %0d exp 4", tif.rd_count); end
    tif.note_length[0 +: LEN_W] = 6'd6;
    tif.load = 4'b0001;
    tick();
    tif.load = 4'b0000;
    #1;
    checks++; if (tif.rd_count !== 6'd6) begin errors++; $display("FAIL rl_restart got %0d exp 6", tif.rd_count); end
    checks++; if (tif.note_end_pulse[0] !== 1'b0) begin errors++; $display("FAIL rl_pulse got %b exp 0", tif.note_end_pulse[0]); end
    checks++; if (tif.ch_state[1:0] !== 2'd1) begin errors++; $display("FAIL rl_state got %0d exp 1", tif.ch_state[1:0]); end
  endtask

`ifdef NOTE_TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    tif.rd_sel = 2'd0;
    tif.auto_repeat = 4'b0001;
    tif.note_length[0 +: LEN_W] = 6'd2;
    tif.load = 4'b0001;
    tick();
    tif.load = 4'b0000;
    #1;
    checks++; if (tif.rd_count !== 6'd2) begin errors++; $display("FAIL ar_load got %0d exp 2", tif.rd_count); end
    for (int k = 1; k <= 6; k++) begin
      give_beat();
      checks++; if (tif.rd_count !== ((k % 2 == 1) ? 6'd1 : 6'd2)) begin errors++; $display("FAIL ar_count got %0d beat %0d", tif.rd_count, k); end
      checks++; if (tif.note_end_pulse[0] !== (k % 2 == 0)) begin errors++; $display("FAIL ar_pulse got %b beat %0d", tif.note_end_pulse[0], k); end
      checks++; if (tif.note_did_end[0] !== 1'b0) begin errors++; $display("FAIL ar_did_end got %b exp 0", tif.note_did_end[0]); end
      checks++; if (tif.ch_state[1:0] !== 2'd1) begin errors++; $display("FAIL ar_state got %0d exp 1", tif.ch_state[1:0]); end
    end
    tif.auto_repeat = 4'b0000;
  endtask
`endif

  task automatic test_midnote_reset();
    tif.rd_sel = 2'd1;
    tif.note_length[LEN_W +: LEN_W] = 6'd1;
    tif.load = 4'b0010;
    tick();
    tif.load = 4'b0000;
    reset_n = 1'b0;
    tif.beat = 1'b1;
    tick();
    reset_n = 1'b1;
    tif.beat = 1'b0;
    #1;
    checks++; if (tif.note_end_pulse !== 4'b0000) begin errors++; $display("FAIL mr_pulse got %b exp 0000", tif.note_end_pulse); end
    checks++; if (tif.ch_state !== 8'h00) begin errors++; $display("FAIL mr_state got %h exp 00", tif.ch_state); end
    checks++; if (tif.any_running !== 1'b0) begin errors++; $display("FAIL mr_any_running got %b exp 0", tif.any_running); end
    checks++; if (tif.note_did_end !== 4'hF) begin errors++; $display("FAIL mr_did_end got %b exp 1111", tif.note_did_end); end
    checks++; if (tif.rd_count !== 6'd0) begin errors++; $display("FAIL mr_count got %0d exp 0", tif.rd_count); end
    tick();
    checks++; if (tif.note_end_pulse !== 4'b0000) begin errors++; $display("FAIL mr_late_pulse got %b exp 0000", tif.note_end_pulse); end
  endtask

  initial begin
    reset_n          = 1'b0;
    tif.beat         = 1'b0;
    tif.load         = '0;
    tif.note_length  = '0;
    tif.pause        = '0;
    tif.rd_sel       = '0;
`ifdef NOTE_TIMER_AUTORELOAD_EN
    tif.auto_repeat  = '0;
`endif
    test_reset();
    test_countdown();
    test_pause();
    test_load_priority();
    test_back_to_back();
`ifdef NOTE_TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    test_midnote_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
